// File: rtl/dac_uart_pkg.sv
// Shared constants and enumerations for the DAC8734 UART command framer.
package dac_uart_pkg;

    localparam logic [7:0] HASH = 8'h23;
    localparam logic [7:0] BANG = 8'h21;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] NINE = 8'h39;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_BIN_NDIG = 4'd1,
        S_BIN_LEN  = 4'd2,
        S_BIN_DATA = 4'd3,
        S_STR_LEN  = 4'd4,
        S_STR_DATA = 4'd5,
        S_TERM_CR  = 4'd6,
        S_TERM_LF  = 4'd7,
        S_DISCARD  = 4'd8
    } parser_state_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_BAD_NDIG  = 3'd1,
        ERR_BAD_DIGIT = 3'd2,
        ERR_LEN_RANGE = 3'd3,
        ERR_BAD_TERM  = 3'd4,
        ERR_TIMEOUT   = 3'd5
    } err_code_e;

    function automatic logic is_ascii_digit(input logic [7:0] b);
        return (b >= ZERO) && (b <= NINE);
    endfunction

endpackage

// File: rtl/dac_uart_len_accum.sv
// Decimal length accumulator (len = len*10 + d) with a sticky overflow flag above MAX_VAL.
module dac_uart_len_accum #(
    parameter int MAX_VAL = 16,
    parameter int W       = $clog2(MAX_VAL + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         acc_en,
    input  logic [3:0]   digit,
    output logic [W-1:0] next_value,
    output logic         next_overflow
);

    logic [W-1:0] value_r;
    logic         overflow_r;
    logic [W+3:0] prod_s;

    // Next value including the digit presented this cycle; the value freezes once it overflows.
    always_comb begin
        prod_s = ({4'b0000, value_r} << 3) + ({4'b0000, value_r} << 1) + {{W{1'b0}}, digit};
        if (overflow_r) begin
            next_value    = value_r;
            next_overflow = 1'b1;
        end else if (prod_s > (W+4)'(MAX_VAL)) begin
            next_value    = value_r;
            next_overflow = 1'b1;
        end else begin
            next_value    = prod_s[W-1:0];
            next_overflow = 1'b0;
        end
    end

    // Accumulator state, cleared outside the length-parsing states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r    <= {W{1'b0}};
            overflow_r <= 1'b0;
        end else if (clear) begin
            value_r    <= {W{1'b0}};
            overflow_r <= 1'b0;
        end else if (acc_en) begin
            value_r    <= next_value;
            overflow_r <= next_overflow;
        end
    end

endmodule

// File: rtl/dac_uart_frame_parser.sv
// UART byte framer for binary (#<n><len><data>\r\n) and text (!<len><chars>\r\n) DAC commands.
// Optional inter-byte timeout is built when DAC_UART_PARSER_TIMEOUT_EN is defined.
module dac_uart_frame_parser
    import dac_uart_pkg::*;
#(
    parameter int MAX_BIN_BYTES  = 16,
    parameter int MAX_CMD_CHARS  = 16,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                               CLK100MHZ,
    input  logic                               resetn,
    input  logic                               rx_valid,
    input  logic [7:0]                         rx_data,
    output logic                               bin_valid,
    output logic [$clog2(MAX_BIN_BYTES+1)-1:0] bin_len,
    output logic [8*MAX_BIN_BYTES-1:0]         bin_data,
    output logic                               cmd_valid,
    output logic [$clog2(MAX_CMD_CHARS+1)-1:0] cmd_len,
    output logic [8*MAX_CMD_CHARS-1:0]         cmd_data,
    output logic                               frame_err,
    output logic [2:0]                         err_code,
    output logic                               busy
);

    localparam int ACC_MAX = (MAX_BIN_BYTES > MAX_CMD_CHARS) ? MAX_BIN_BYTES : MAX_CMD_CHARS;
    localparam int ACC_W   = $clog2(ACC_MAX + 1);
    localparam int LB      = $clog2(MAX_BIN_BYTES + 1);
    localparam int LC      = $clog2(MAX_CMD_CHARS + 1);

    parser_state_e          state_r;
    err_code_e              err_code_r;
    logic                   is_bin_r;
    logic [3:0]             ndig_r;
    logic [3:0]             dig_cnt_r;
    logic [ACC_W-1:0]       len_r;
    logic [ACC_W-1:0]       idx_r;
    logic [8*ACC_MAX-1:0]   work_r;
    logic [8*ACC_MAX-1:0]   masked_s;

    logic                   is_digit_s;
    logic                   acc_clear_s;
    logic                   acc_en_s;
    logic [ACC_W-1:0]       acc_next_s;
    logic                   acc_next_ovf_s;
    logic [ACC_W-1:0]       len_limit_s;
    logic                   len_bad_s;
    logic                   last_byte_s;
    parser_state_e          err_state_s;
    parser_state_e          start_state_s;
    logic                   tmo_hit_s;

    assign busy     = (state_r != S_IDLE);
    assign err_code = err_code_r;

    dac_uart_len_accum #(
        .MAX_VAL (ACC_MAX),
        .W       (ACC_W)
    ) u_len_accum (
        .clk           (CLK100MHZ),
        .rst_n         (resetn),
        .clear         (acc_clear_s),
        .acc_en        (acc_en_s),
        .digit         (rx_data[3:0]),
        .next_value    (acc_next_s),
        .next_overflow (acc_next_ovf_s)
    );

    // Byte classification, length range check and shared next-state choices.
    always_comb begin
        is_digit_s  = is_ascii_digit(rx_data);
        acc_clear_s = (state_r != S_BIN_LEN) && (state_r != S_STR_LEN);
        acc_en_s    = rx_valid && !acc_clear_s && is_digit_s;
        if (state_r == S_STR_LEN) begin
            len_limit_s = ACC_W'(MAX_CMD_CHARS);
        end else begin
            len_limit_s = ACC_W'(MAX_BIN_BYTES);
        end
        len_bad_s   = acc_next_ovf_s || (acc_next_s == {ACC_W{1'b0}}) || (acc_next_s > len_limit_s);
        last_byte_s = ((idx_r + ACC_W'(1)) == len_r);
        if (rx_data == LF) begin
            err_state_s = S_IDLE;
        end else begin
            err_state_s = S_DISCARD;
        end
        if (rx_data == HASH) begin
            start_state_s = S_BIN_NDIG;
        end else if (rx_data == BANG) begin
            start_state_s = S_STR_LEN;
        end else begin
            start_state_s = S_IDLE;
        end
    end

    // Working buffer with bytes at or beyond len forced to zero for delivery.
    always_comb begin
        masked_s = {(8*ACC_MAX){1'b0}};
        for (int i = 0; i < ACC_MAX; i++) begin
            if (ACC_W'(i) < len_r) begin
                masked_s[8*i +: 8] = work_r[8*i +: 8];
            end else begin
                masked_s[8*i +: 8] = 8'h00;
            end
        end
    end

`ifdef DAC_UART_PARSER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    assign tmo_hit_s = (state_r != S_IDLE) && !rx_valid &&
                       (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 32'sd1));

    // Idle-gap counter: restarts on each byte, parked at zero outside a frame.
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_r == S_IDLE) || rx_valid || tmo_hit_s) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end
`else
    logic unused_tmo_s;

    // TIMEOUT_CYCLES has no function without the timeout counter.
    assign tmo_hit_s    = 1'b0;
    assign unused_tmo_s = (TIMEOUT_CYCLES == 32'sd0);
`endif

    // Parser FSM with registered strobes, held frame outputs and error reporting.
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            state_r    <= S_IDLE;
            err_code_r <= ERR_NONE;
            is_bin_r   <= 1'b0;
            ndig_r     <= 4'd0;
            dig_cnt_r  <= 4'd0;
            len_r      <= {ACC_W{1'b0}};
            idx_r      <= {ACC_W{1'b0}};
            work_r     <= {(8*ACC_MAX){1'b0}};
            bin_valid  <= 1'b0;
            bin_len    <= {LB{1'b0}};
            bin_data   <= {(8*MAX_BIN_BYTES){1'b0}};
            cmd_valid  <= 1'b0;
            cmd_len    <= {LC{1'b0}};
            cmd_data   <= {(8*MAX_CMD_CHARS){1'b0}};
            frame_err  <= 1'b0;
        end else begin
            bin_valid <= 1'b0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            if (tmo_hit_s) begin
                frame_err  <= 1'b1;
                err_code_r <= ERR_TIMEOUT;
                state_r    <= S_IDLE;
            end else if (rx_valid) begin
                case (state_r)
                    S_IDLE: begin
                        is_bin_r <= (rx_data == HASH);
                        state_r  <= start_state_s;
                    end
                    S_BIN_NDIG: begin
                        if (is_digit_s && (rx_data != ZERO)) begin
                            ndig_r    <= rx_data[3:0];
                            dig_cnt_r <= 4'd0;
                            state_r   <= S_BIN_LEN;
                        end else begin
                            frame_err  <= 1'b1;
                            err_code_r <= ERR_BAD_NDIG;
                            state_r    <= err_state_s;
                        end
                    end
                    S_BIN_LEN, S_STR_LEN: begin
                        if (!is_digit_s) begin
                            frame_err  <= 1'b1;
                            err_code_r <= ERR_BAD_DIGIT;
                            state_r    <= err_state_s;
                        end else if ((state_r == S_BIN_LEN) && ((dig_cnt_r + 4'd1) != ndig_r)) begin
                            dig_cnt_r <= dig_cnt_r + 4'd1;
                        end else if (len_bad_s) begin
                            frame_err  <= 1'b1;
                            err_code_r <= ERR_LEN_RANGE;
                            state_r    <= err_state_s;
                        end else begin
                            len_r   <= acc_next_s;
                            idx_r   <= {ACC_W{1'b0}};
                            state_r <= (state_r == S_BIN_LEN) ? S_BIN_DATA : S_STR_DATA;
                        end
                    end
                    S_BIN_DATA, S_STR_DATA: begin
                        work_r[{idx_r, 3'b000} +: 8] <= rx_data;
                        idx_r <= idx_r + ACC_W'(1);
                        if (last_byte_s) begin
                            state_r <= S_TERM_CR;
                        end
                    end
                    S_TERM_CR: begin
                        if (rx_data == CR) begin
                            state_r <= S_TERM_LF;
                        end else begin
                            frame_err  <= 1'b1;
                            err_code_r <= ERR_BAD_TERM;
                            state_r    <= err_state_s;
                        end
                    end
                    S_TERM_LF: begin
                        if (rx_data == LF) begin
                            state_r <= S_IDLE;
                            if (is_bin_r) begin
                                bin_valid <= 1'b1;
                                bin_len   <= LB'(len_r);
                                bin_data  <= masked_s[8*MAX_BIN_BYTES-1:0];
                            end else begin
                                cmd_valid <= 1'b1;
                                cmd_len   <= LC'(len_r);
                                cmd_data  <= masked_s[8*MAX_CMD_CHARS-1:0];
                            end
                        end else begin
                            frame_err  <= 1'b1;
                            err_code_r <= ERR_BAD_TERM;
                            // A frame opener here starts a new frame instead of being discarded.
                            if ((rx_data == HASH) || (rx_data == BANG)) begin
                                is_bin_r <= (rx_data == HASH);
                                state_r  <= start_state_s;
                            end else begin
                                state_r  <= err_state_s;
                            end
                        end
                    end
                    S_DISCARD: begin
                        if (rx_data == LF) begin
                            state_r <= S_IDLE;
                        end
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_uart_frame_parser.sv
// Directed self-checking bench for dac_uart_frame_parser; timeout case needs DAC_UART_PARSER_TIMEOUT_EN.
module tb_dac_uart_frame_parser;

    logic         clk = 1'b0;
    logic         resetn;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         bin_valid;
    logic [4:0]   bin_len;
    logic [127:0] bin_data;
    logic         cmd_valid;
    logic [4:0]   cmd_len;
    logic [127:0] cmd_data;
    logic         frame_err;
    logic [2:0]   err_code;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_send_cyc = 0;
    int bin_cnt = 0, bin_last_cyc = 0, bin_prev_cyc = 0;
    int cmd_cnt = 0;
    int err_cnt = 0, err_last_cyc = 0;
    int b0, c0, e0, t0;

    always #5 clk = ~clk;

    dac_uart_frame_parser #(
        .MAX_BIN_BYTES  (16),
        .MAX_CMD_CHARS  (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .CLK100MHZ (clk),
        .resetn    (resetn),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .bin_valid (bin_valid),
        .bin_len   (bin_len),
        .bin_data  (bin_data),
        .cmd_valid (cmd_valid),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    // Strobe monitor sampling just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bin_valid) begin
            bin_cnt++;
            bin_prev_cyc = bin_last_cyc;
            bin_last_cyc = cyc;
        end
        if (cmd_valid) cmd_cnt++;
        if (frame_err) begin
            err_cnt++;
            err_last_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        last_send_cyc = cyc;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic send_bytes(input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) send(v[8*i +: 8]);
    endtask

    task automatic crlf();
        send_bytes(2, 64'h0A0D);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_bin_valid"}, bin_valid, 1'b0);
        chk({tag, "_bin_len"},   bin_len, 5'd0);
        chk({tag, "_bin_data"},  bin_data, 128'h0);
        chk({tag, "_cmd_valid"}, cmd_valid, 1'b0);
        chk({tag, "_cmd_len"},   cmd_len, 5'd0);
        chk({tag, "_cmd_data"},  cmd_data, 128'h0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
        chk({tag, "_err_code"},  err_code, 3'd0);
        chk({tag, "_busy"},      busy, 1'b0);
    endtask

    initial begin
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        check_all_zero("reset");
        resetn = 1'b1;
        idle(2);

        // Binary frame #14 01 04 19 99
        b0 = bin_cnt; e0 = err_cnt;
        send_str("#14"); send_bytes(4, 64'h99190401); crlf();
        chk("bin1_latency", bin_last_cyc, last_send_cyc);
        idle(2);
        chk("bin1_cnt", bin_cnt - b0, 1);
        chk("bin1_len", bin_len, 5'd4);
        chk("bin1_data", bin_data, 128'h99190401);
        chk("bin1_noerr", err_cnt - e0, 0);
        chk("bin1_busy", busy, 1'b0);

        // Text frame !9WRITE REG
        c0 = cmd_cnt;
        send_str("!9WRITE REG"); crlf();
        idle(2);
        chk("cmd1_cnt", cmd_cnt - c0, 1);
        chk("cmd1_len", cmd_len, 5'd9);
        chk("cmd1_first", cmd_data[7:0], 8'h57);
        chk("cmd1_last", cmd_data[71:64], 8'h47);
        chk("cmd1_upper", cmd_data[127:72], 56'h0);
        chk("cmd1_bin_held", bin_data, 128'h99190401);
        chk("cmd1_binlen_held", bin_len, 5'd4);

        // Missing CR: 0x99 lands on the CR check
        b0 = bin_cnt; e0 = err_cnt;
        send_str("#14"); send_bytes(7, 64'h0A0D99_19041010);
        idle(2);
        chk("badterm_err", err_cnt - e0, 1);
        chk("badterm_code", err_code, 3'd4);
        chk("badterm_nobin", bin_cnt - b0, 0);
        chk("badterm_busy", busy, 1'b0);
        send_str("#14"); send_bytes(4, 64'h99190480); crlf();
        idle(2);
        chk("resync_data", bin_data, 128'h99190480);

        // Payload holding CR/LF, zero-filled above len
        send_str("#12"); send_bytes(4, 64'h0A0D0A0D);
        idle(2);
        chk("crlf_len", bin_len, 5'd2);
        chk("crlf_data", bin_data, 128'h0A0D);

        // Length range / bad digit / bad ndig / text zero length
        send_str("#220"); idle(2);
        chk("range_code", err_code, 3'd3);
        send(8'h0A); idle(1);
        chk("range_busy", busy, 1'b0);
        send_str("#1A"); idle(2);
        chk("digit_code", err_code, 3'd2);
        send(8'h0A);
        send_str("#0"); idle(2);
        chk("ndig_code", err_code, 3'd1);
        send(8'h0A);
        e0 = err_cnt;
        send_str("!0"); idle(2);
        chk("strzero_code", err_code, 3'd3);
        chk("strzero_err", err_cnt - e0, 1);
        send(8'h0A); idle(1);

        // '#' at the LF check restarts a new frame
        b0 = bin_cnt;
        send_str("#12"); send_bytes(3, 64'h0DCDAB); send_str("#14");
        send_bytes(4, 64'h04030201); crlf();
        idle(2);
        chk("restart_code", err_code, 3'd4);
        chk("restart_cnt", bin_cnt - b0, 1);
        chk("restart_data", bin_data, 128'h04030201);

        // Back-to-back frames, 7 then 8 bytes
        b0 = bin_cnt;
        send_str("#12"); send_bytes(4, 64'h0A0D2211);
        send_str("#13"); send_bytes(5, 64'h0A0D554433);
        idle(2);
        chk("b2b_cnt", bin_cnt - b0, 2);
        chk("b2b_spacing", bin_last_cyc - bin_prev_cyc, 8);
        chk("b2b_len", bin_len, 5'd3);
        chk("b2b_data", bin_data, 128'h554433);

        // Reset in mid-payload
        b0 = bin_cnt;
        send_str("#14"); send_bytes(2, 64'h0201);
        resetn = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        send_str("#11"); send(8'h5A); crlf();
        idle(2);
        chk("post_reset_cnt", bin_cnt - b0, 1);
        chk("post_reset_len", bin_len, 5'd1);
        chk("post_reset_data", bin_data, 128'h5A);

`ifdef DAC_UART_PARSER_TIMEOUT_EN
        e0 = err_cnt;
        send_str("#14"); send(8'h01);
        t0 = last_send_cyc;
        for (int i = 0; i < 200 && err_cnt == e0; i++) @(negedge clk);
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_code", err_code, 3'd5);
        chk("tmo_latency", err_last_cyc - t0, 100);
        chk("tmo_busy", busy, 1'b0);
        b0 = bin_cnt;
        send_str("#12"); send_bytes(4, 64'h0A0DBEEF);
        idle(2);
        chk("tmo_next_cnt", bin_cnt - b0, 1);
        chk("tmo_next_data", bin_data, 128'hBEEF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_uart_frame_parser.md
Name: dac_uart_frame_parser

Overview:
- Byte-level command framer between the UART receiver and the DAC8734 command dispatcher.
- Consumes received bytes and recognises two frame types:
  - binary frames `#<ndig><len><payload>\r\n`, e.g. `#14` + 4 raw bytes (DAC select mask + 24-bit DAC word);
  - text frames `!<len><chars>\r\n`, e.g. `!9WRITE REG`.
- Delivers each complete frame as a held parallel buffer plus a one-cycle valid strobe.
- Reports malformed frames with an error strobe and code, then resynchronises on the next LF.

Parameters:
- MAX_BIN_BYTES, 16, capacity of the binary payload buffer in bytes.
- MAX_CMD_CHARS, 16, capacity of the text command buffer in characters; must be >= 9.
- TIMEOUT_CYCLES, 10_000_000, idle cycles allowed between bytes of one frame (used only with the optional feature).

Ports:
- CLK100MHZ  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- bin_valid  out  1  one-cycle strobe: binary frame complete.
- bin_len  out  $clog2(MAX_BIN_BYTES+1)  payload byte count.
- bin_data  out  8*MAX_BIN_BYTES  payload; first received byte in [7:0].
- cmd_valid  out  1  one-cycle strobe: text frame complete.
- cmd_len  out  $clog2(MAX_CMD_CHARS+1)  character count.
- cmd_data  out  8*MAX_CMD_CHARS  characters; first received character in [7:0].
- frame_err  out  1  one-cycle strobe: frame rejected.
- err_code  out  3  1 BAD_NDIG, 2 BAD_DIGIT, 3 LEN_RANGE, 4 BAD_TERM, 5 TIMEOUT; held until the next error.
- busy  out  1  high while in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, CLK100MHZ; resetn is asynchronous, active-low.
- Reset values: all outputs 0; FSM goes to IDLE; the working buffer is cleared. Reset in mid-frame discards the partial frame and produces no strobe.
- Input acceptance: no backpressure. A byte is accepted on every cycle where rx_valid=1, including back-to-back cycles.
- FSM states: IDLE, BIN_NDIG, BIN_LEN, BIN_DATA, STR_LEN, STR_DATA, TERM_CR, TERM_LF, DISCARD.
- IDLE:
  - `#` (0x23) -> BIN_NDIG.
  - `!` (0x21) -> STR_LEN.
  - Any other byte, including a stray CR/LF, is ignored silently.
- BIN_NDIG: `1`..`9` sets the digit count n and goes to BIN_LEN. Any other byte -> error BAD_NDIG.
- BIN_LEN:
  - Accumulates n ASCII decimal digits: len = len*10 + d.
  - A sticky overflow flag is set once len exceeds MAX_BIN_BYTES, so no wide multiplier is required.
  - A non-digit byte -> BAD_DIGIT.
  - After the nth digit: len = 0 or overflow -> LEN_RANGE; otherwise -> BIN_DATA.
- STR_LEN: accepts a single digit `1`..`9`.
  - `0` -> LEN_RANGE; a non-digit -> BAD_DIGIT.
  - len > MAX_CMD_CHARS -> LEN_RANGE.
- BIN_DATA / STR_DATA:
  - Stores exactly len raw bytes into the working buffer at index 0..len-1, then goes to TERM_CR.
  - Payload bytes are never interpreted: 0x0D, 0x0A, `#` and `!` inside a payload are data.
- TERM_CR: requires 0x0D, else BAD_TERM.
- TERM_LF: requires 0x0A, else BAD_TERM.
- On the accepted LF, on the next clock edge:
  - The working buffer is copied to bin_data/cmd_data with bytes >= len zero-filled.
  - The matching len output is updated and the valid strobe is pulsed for 1 cycle.
  - The FSM returns to IDLE.
  - Latency: strobe is high in the cycle after the LF's rx_valid cycle.
- Output hold: outputs keep their values until the next successful frame of the same type. Parsing a new frame never disturbs the held outputs.
- Error handling:
  - frame_err is pulsed for 1 cycle and err_code is set, in the cycle after the offending byte.
  - FSM -> DISCARD, except BAD_TERM on the LF check when the offending byte is itself `#` or `!`: in that case the byte restarts the parse as in IDLE.
  - DISCARD drops bytes until 0x0A, then returns to IDLE.
  - If the offending byte is itself 0x0A, the FSM returns directly to IDLE.

Optional Feature:
- Macro: DAC_UART_PARSER_TIMEOUT_EN.
- Defined:
  - A counter clears on every rx_valid and counts while busy=1.
  - Reaching TIMEOUT_CYCLES pulses frame_err with err_code=5 (TIMEOUT) and forces the FSM to IDLE (not DISCARD).
  - The counter is held at 0 in IDLE.
- Undefined: no counter is built, and a partial frame waits indefinitely.

Decomposition:
- Package dac_uart_pkg holds:
  - ASCII constants (HASH, BANG, CR, LF, ZERO, NINE);
  - the parser state enum;
  - the err_code enum.
- Sub-module: dac_uart_len_accum, a decimal digit accumulator with saturation/overflow flag, reused by both length states. Everything else stays in this module.

Test Plan:
- Binary frame: send `#14 01 04 19 99 0D 0A` -> exactly one bin_valid pulse, bin_len=4, bin_data[31:0]=0x99190401, upper bits 0, no frame_err.
- Text frame: send `!9WRITE REG\r\n` -> cmd_valid, cmd_len=9, cmd_data[7:0]=0x57 (`W`), cmd_data[71:64]=0x47 (`G`); bin outputs keep their previous values.
- Malformed frame: send `#14 10 10 04 19 99 0D 0A` -> frame_err with err_code=4 (byte 0x99 at CR check), then DISCARD until LF. The following `#14 80 04 19 99 0D 0A` -> bin_data[31:0]=0x99190480.
- Payload containing CR/LF: send `#12 0D 0A 0D 0A` -> bin_len=2, bin_data[15:0]=0x0A0D. Send `#220...` with MAX_BIN_BYTES=16 -> err_code=3. Send `#1A` -> err_code=2.
- Back-to-back and reset: feed two frames with rx_valid high on consecutive cycles -> two valid strobes spaced exactly by the byte count. Assert resetn low mid-payload -> all outputs 0, busy=0, and the next frame parses correctly.
- Timeout (with DAC_UART_PARSER_TIMEOUT_EN, TIMEOUT_CYCLES=100): send `#14 01` then stay silent -> frame_err with err_code=5 at cycle 100 after the last byte, busy=0. A subsequent valid frame is accepted.
